// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the multiplier scheduler and the multiplier itself.
package mult_sched_pkg;

  localparam int unsigned NEntryRob        = 32;
  localparam int unsigned NumMultStagesDef = 8;
  localparam int unsigned StackNum         = 4;
  localparam int unsigned TagW             = $clog2(NEntryRob + 33);
  localparam int unsigned BrAddrW          = $clog2(StackNum);

  typedef logic [TagW-1:0]     tag_t;
  typedef logic [StackNum-1:0] b_mask_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] product;
    tag_t        tag;
    b_mask_t     b_mask;
  } mult_buf_entry_t;

  function automatic logic mask_hit(b_mask_t a, b_mask_t b);
    return |(a & b);
  endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Bundle of issue, multiplier, branch and CDB signals around the multiplier scheduler.
interface mult_sched_if #(
  parameter int unsigned NumReq = 2
);
  import mult_sched_pkg::*;

  logic [NumReq-1:0]       rs_req;
  logic [NumReq-1:0][63:0] rs_mcand;
  logic [NumReq-1:0][63:0] rs_mplier;
  tag_t [NumReq-1:0]       rs_tag;
  b_mask_t [NumReq-1:0]    rs_b_mask;
  logic [NumReq-1:0]       rs_gnt;

  logic                    mult_start;
  logic [63:0]             mult_mcand;
  logic [63:0]             mult_mplier;
  tag_t                    mult_tag;
  logic                    mult_done;
  logic [63:0]             mult_product;
  tag_t                    mult_tag_out;

  logic                    br_correct;
  logic [BrAddrW-1:0]      br_correct_address;
  logic                    recovery_request;
  b_mask_t                 recovery_b_mask;

  logic                    cdb_req;
  logic                    cdb_gnt;
  logic [63:0]             cdb_value;
  tag_t                    cdb_tag;

  modport master (
    input  rs_req, rs_mcand, rs_mplier, rs_tag, rs_b_mask,
    output rs_gnt,
    output mult_start, mult_mcand, mult_mplier, mult_tag,
    input  mult_done, mult_product, mult_tag_out,
    input  br_correct, br_correct_address, recovery_request, recovery_b_mask,
    output cdb_req, cdb_value, cdb_tag,
    input  cdb_gnt
  );

  modport slave (
    output rs_req, rs_mcand, rs_mplier, rs_tag, rs_b_mask,
    input  rs_gnt,
    input  mult_start, mult_mcand, mult_mplier, mult_tag,
    output mult_done, mult_product, mult_tag_out,
    output br_correct, br_correct_address, recovery_request, recovery_b_mask,
    input  cdb_req, cdb_value, cdb_tag,
    output cdb_gnt
  );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves to winner+1 on a grant.
module rr_arbiter #(
  parameter int unsigned NumReq = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o
);
  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [2*NumReq-1:0] req_rot;
  logic                found;
  int unsigned         win;

  always_comb begin
    // Rotate so bit 0 is the requester at the pointer.
    req_rot = {req_i, req_i} >> ptr_q;
    found   = 1'b0;
    win     = 0;
    gnt_o   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        win   = (i + 32'(ptr_q)) % NumReq;
      end
    end
    for (int unsigned j = 0; j < NumReq; j++) begin
      gnt_o[j] = found && (win == j);
    end
    ptr_d = found ? PtrW'((win + 1) % NumReq) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult_sched.sv
// Issue/writeback scheduler for the pipelined multiplier: credit-gated RR issue, shadow
// pipe of valid/branch masks with squash, and a completion FIFO draining to the CDB.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned NumMultStages = NumMultStagesDef,
  parameter int unsigned BufDepth      = 8
) (
  input logic          clk_i,
  input logic          rst_ni,
  mult_sched_if.master bus
);
  localparam int unsigned BufPtrW   = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int unsigned CntW      = $clog2(BufDepth + 1);
  localparam int unsigned LastStage = NumMultStages - 1;

  logic [NumReq-1:0]              req_elig, gnt;
  logic                           grant, credit_ok, last_live, push, pop, buf_nonempty;
  b_mask_t                        clr_mask, kill_mask, win_mask;
  mult_buf_entry_t                head;
  logic [NumMultStages-1:0]       sh_valid_q, sh_valid_d;
  b_mask_t [NumMultStages-1:0]    sh_mask_q, sh_mask_d;
  mult_buf_entry_t [BufDepth-1:0] buf_q, buf_d;
  logic [BufPtrW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]                count_q, count_d, credits_q, credits_d;
  int unsigned                    live_cnt;

  function automatic logic [BufPtrW-1:0] ptr_inc(logic [BufPtrW-1:0] p);
    return (32'(p) == BufDepth - 1) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(.NumReq(NumReq)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_elig),
    .gnt_o  (gnt)
  );

  always_comb begin
    clr_mask  = bus.br_correct ? (b_mask_t'(1) << bus.br_correct_address) : '0;
    kill_mask = bus.recovery_request ? bus.recovery_b_mask : '0;
    credit_ok = credits_q < CntW'(BufDepth);

    for (int unsigned i = 0; i < NumReq; i++) begin
      req_elig[i] = rst_ni && credit_ok && bus.rs_req[i] && !mask_hit(bus.rs_b_mask[i], kill_mask);
    end
    grant = |gnt;

    bus.rs_gnt      = gnt;
    bus.mult_start  = grant;
    bus.mult_mcand  = '0;
    bus.mult_mplier = '0;
    bus.mult_tag    = '0;
    win_mask        = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (gnt[i]) begin
        bus.mult_mcand  = bus.rs_mcand[i];
        bus.mult_mplier = bus.rs_mplier[i];
        bus.mult_tag    = bus.rs_tag[i];
        win_mask        = bus.rs_b_mask[i];
      end
    end

    sh_valid_d[0] = grant;
    sh_mask_d[0]  = win_mask & ~clr_mask;
    for (int unsigned k = 1; k < NumMultStages; k++) begin
      sh_valid_d[k] = sh_valid_q[k-1] && !mask_hit(sh_mask_q[k-1], kill_mask);
      sh_mask_d[k]  = sh_mask_q[k-1] & ~clr_mask;
    end
    last_live = sh_valid_q[LastStage] && !mask_hit(sh_mask_q[LastStage], kill_mask);
    push      = last_live && bus.mult_done;

    head          = buf_q[head_q];
    buf_nonempty  = count_q != '0;
    bus.cdb_req   = buf_nonempty && head.valid && !mask_hit(head.b_mask, kill_mask);
    bus.cdb_value = head.product;
    bus.cdb_tag   = head.tag;
    // Bubbles left by squashed entries drain from the head one per cycle.
    pop = (bus.cdb_req && bus.cdb_gnt) || (buf_nonempty && !head.valid);

    buf_d = buf_q;
    for (int unsigned e = 0; e < BufDepth; e++) begin
      buf_d[e].valid  = buf_q[e].valid && !mask_hit(buf_q[e].b_mask, kill_mask);
      buf_d[e].b_mask = buf_q[e].b_mask & ~clr_mask;
    end
    if (push) begin
      buf_d[tail_q] = '{valid:   1'b1,
                        product: bus.mult_product,
                        tag:     bus.mult_tag_out,
                        b_mask:  sh_mask_q[LastStage] & ~clr_mask};
    end
    head_d  = pop  ? ptr_inc(head_q) : head_q;
    tail_d  = push ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + CntW'(push) - CntW'(pop);

    // Bubbles keep their slot until popped, so the FIFO slots can never be oversubscribed.
    live_cnt = 0;
    for (int unsigned k = 0; k < NumMultStages; k++) begin
      live_cnt = live_cnt + 32'(sh_valid_d[k]);
    end
    credits_d = CntW'(live_cnt) + count_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_valid_q <= '0;
      sh_mask_q  <= '0;
      buf_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      credits_q  <= '0;
    end else begin
      sh_valid_q <= sh_valid_d;
      sh_mask_q  <= sh_mask_d;
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      credits_q  <= credits_d;
    end
  end

  a_done_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sh_valid_q[LastStage] |-> bus.mult_done);

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched with a behavioural 8-stage multiplier alongside.
module tb_mult_sched;
  import mult_sched_pkg::*;

  localparam int unsigned NumReq = 2;
  localparam int unsigned Stages = 8;
  localparam int unsigned Depth  = 8;

  typedef struct {
    logic [63:0] value;
    tag_t        tag;
    b_mask_t     b_mask;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  int unsigned n_bcast = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  b_mask_t     mon_clr, mon_kill;

  always #5 clk = ~clk;

  mult_sched_if #(.NumReq(NumReq)) bus ();

  mult_sched #(.NumReq(NumReq), .NumMultStages(Stages), .BufDepth(Depth)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Multiplier model: never reset, so stale done pulses can follow a reset.
  logic [Stages-1:0] mp_v = '0;
  logic [63:0]       mp_p[Stages];
  tag_t              mp_t[Stages];
  always @(posedge clk) begin
    mp_v    <= {mp_v[Stages-2:0], bus.mult_start};
    mp_p[0] <= bus.mult_mcand * bus.mult_mplier;
    mp_t[0] <= bus.mult_tag;
    for (int k = 1; k < Stages; k++) begin
      mp_p[k] <= mp_p[k-1];
      mp_t[k] <= mp_t[k-1];
    end
  end
  assign bus.mult_done    = mp_v[Stages-1];
  assign bus.mult_product = mp_p[Stages-1];
  assign bus.mult_tag_out = mp_t[Stages-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on broadcast, then squash/clear, then push the new issue.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_clr  = bus.br_correct ? (b_mask_t'(1) << bus.br_correct_address) : '0;
      mon_kill = bus.recovery_request ? bus.recovery_b_mask : '0;
      if (bus.cdb_req && bus.cdb_gnt) begin
        n_bcast++;
        check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check_eq("cdb_value", bus.cdb_value, mon_e.value);
          check_eq("cdb_tag", 64'(bus.cdb_tag), 64'(mon_e.tag));
          check_eq("cdb_squashed", 64'(|(mon_e.b_mask & mon_kill)), 64'd0);
        end
      end
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (|(sb_q[i].b_mask & mon_kill)) sb_q.delete(i);
      end
      foreach (sb_q[i]) sb_q[i].b_mask = sb_q[i].b_mask & ~mon_clr;
      if (bus.mult_start) begin
        check_eq("gnt_onehot", 64'($onehot(bus.rs_gnt)), 64'd1);
        for (int i = 0; i < NumReq; i++) begin
          if (bus.rs_gnt[i]) begin
            mon_e.value  = bus.rs_mcand[i] * bus.rs_mplier[i];
            mon_e.tag    = bus.rs_tag[i];
            mon_e.b_mask = bus.rs_b_mask[i] & ~mon_clr;
            sb_q.push_back(mon_e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rs_req             = '0;
    bus.rs_mcand           = '0;
    bus.rs_mplier          = '0;
    bus.rs_tag             = '0;
    bus.rs_b_mask          = '0;
    bus.br_correct         = 1'b0;
    bus.br_correct_address = '0;
    bus.recovery_request   = 1'b0;
    bus.recovery_b_mask    = '0;
    bus.cdb_gnt            = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    sb_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int r, input logic [63:0] a, input logic [63:0] b,
                        input tag_t t, input b_mask_t m);
    bus.rs_mcand[r]  = a;
    bus.rs_mplier[r] = b;
    bus.rs_tag[r]    = t;
    bus.rs_b_mask[r] = m;
  endtask

  task automatic rand_ops(input int c);
    set_op(0, {$urandom, $urandom}, {$urandom, $urandom}, tag_t'(2 * c), '0);
    set_op(1, {$urandom, $urandom}, {$urandom, $urandom}, tag_t'(2 * c + 1), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int      ngr, lat, nb0;
    logic [1:0] rr_exp[4];
    b_mask_t sq_mask[3];
    rr_exp  = '{2'b01, 2'b10, 2'b01, 2'b10};
    sq_mask = '{4'b0001, 4'b0010, 4'b0001};

    // Outputs held at zero during reset even with requests pending.
    idle_inputs();
    bus.rs_req = 2'b11;
    set_op(0, 64'd21, 64'd2, tag_t'(9), '0);
    set_op(1, 64'd33, 64'd4, tag_t'(10), '0);
    @(negedge clk);
    check_eq("rst_gnt", bus.rs_gnt, 0);
    check_eq("rst_start", bus.mult_start, 0);
    check_eq("rst_mcand", bus.mult_mcand, 0);
    check_eq("rst_tag", bus.mult_tag, 0);
    check_eq("rst_cdb_req", bus.cdb_req, 0);
    check_eq("rst_cdb_value", bus.cdb_value, 0);
    check_eq("rst_cdb_tag", bus.cdb_tag, 0);

    // Single op: 3*5, first cdb_req 9 cycles after grant.
    do_reset();
    set_op(0, 64'd3, 64'd5, tag_t'(7'h11), '0);
    bus.rs_req = 2'b01;
    @(negedge clk);
    check_eq("t1_gnt", bus.rs_gnt, 2'b01);
    check_eq("t1_mcand", bus.mult_mcand, 3);
    check_eq("t1_mplier", bus.mult_mplier, 5);
    check_eq("t1_tag", bus.mult_tag, 7'h11);
    step();
    bus.rs_req = '0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.cdb_req) break;
    end
    check_eq("t1_latency", lat, 9);
    check_eq("t1_value", bus.cdb_value, 15);
    check_eq("t1_cdb_tag", bus.cdb_tag, 7'h11);
    step();
    @(negedge clk);
    check_eq("t1_popped", bus.cdb_req, 0);
    step();
    check_eq("t1_credits", dut.credits_q, 0);

    // Round robin with both requesting.
    do_reset();
    bus.rs_req = 2'b11;
    for (int c = 0; c < 4; c++) begin
      rand_ops(c);
      @(negedge clk);
      check_eq("t2_gnt", bus.rs_gnt, rr_exp[c]);
      step();
    end
    bus.rs_req = '0;
    @(negedge clk);
    check_eq("t2_ptr", dut.u_arb.ptr_q, 0);
    repeat (15) step();
    check_eq("t2_drained", sb_q.size(), 0);

    // Backpressure: credits cap in-flight ops at the buffer depth.
    do_reset();
    bus.cdb_gnt = 1'b0;
    bus.rs_req  = 2'b11;
    ngr = 0;
    for (int c = 0; c < 20; c++) begin
      rand_ops(c);
      @(negedge clk);
      if (bus.mult_start) ngr++;
      step();
    end
    check_eq("t3_grants", ngr, 8);
    @(negedge clk);
    check_eq("t3_gnt_blocked", bus.rs_gnt, 0);
    check_eq("t3_cdb_req", bus.cdb_req, 1);
    step();
    bus.cdb_gnt = 1'b1;
    @(negedge clk);
    check_eq("t3_gnt_same_cycle", bus.rs_gnt, 0);
    step();
    bus.cdb_gnt = 1'b0;
    ngr = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("t3_gnt_next_cycle", 64'(bus.rs_gnt != 0), 1);
      if (bus.mult_start) ngr++;
      step();
    end
    check_eq("t3_regrant", ngr, 1);
    bus.rs_req  = '0;
    bus.cdb_gnt = 1'b1;
    repeat (25) step();
    check_eq("t3_credits", dut.credits_q, 0);
    check_eq("t3_drained", sb_q.size(), 0);

    // Squash mid-pipe: only the 0010 op survives.
    do_reset();
    nb0 = n_bcast;
    bus.rs_req = 2'b01;
    for (int c = 0; c < 3; c++) begin
      set_op(0, 64'(c + 2), 64'd10, tag_t'(c + 20), sq_mask[c]);
      @(negedge clk);
      check_eq("t4_gnt", bus.rs_gnt, 2'b01);
      step();
    end
    bus.rs_req = '0;
    step();
    bus.recovery_request = 1'b1;
    bus.recovery_b_mask  = 4'b0001;
    step();
    bus.recovery_request = 1'b0;
    bus.recovery_b_mask  = '0;
    repeat (20) step();
    check_eq("t4_bcast", n_bcast - nb0, 1);
    check_eq("t4_credits", dut.credits_q, 0);

    // Branch correct clears the bit both in the shadow pipe and in the buffer.
    do_reset();
    bus.cdb_gnt = 1'b0;
    nb0 = n_bcast;
    set_op(0, 64'd7, 64'd9, tag_t'(5), 4'b0001);
    bus.rs_req = 2'b01;
    step();
    set_op(0, 64'd6, 64'd8, tag_t'(6), 4'b0010);
    step();
    bus.rs_req = '0;
    step();
    bus.br_correct         = 1'b1;
    bus.br_correct_address = 2'd0;
    step();
    bus.br_correct = 1'b0;
    step();
    bus.recovery_request = 1'b1;
    bus.recovery_b_mask  = 4'b0001;
    step();
    bus.recovery_request = 1'b0;
    bus.recovery_b_mask  = '0;
    repeat (8) step();
    bus.br_correct         = 1'b1;
    bus.br_correct_address = 2'd1;
    step();
    bus.br_correct       = 1'b0;
    bus.recovery_request = 1'b1;
    bus.recovery_b_mask  = 4'b0010;
    step();
    bus.recovery_request = 1'b0;
    bus.recovery_b_mask  = '0;
    bus.cdb_gnt          = 1'b1;
    repeat (6) step();
    check_eq("t5_bcast", n_bcast - nb0, 2);

    // Head killed while granted: no broadcast, next entry follows.
    do_reset();
    bus.cdb_gnt = 1'b0;
    set_op(0, 64'd11, 64'd13, tag_t'(30), 4'b0100);
    bus.rs_req = 2'b01;
    step();
    set_op(0, 64'd17, 64'd19, tag_t'(31), '0);
    step();
    bus.rs_req = '0;
    repeat (12) step();
    @(negedge clk);
    check_eq("t6_head_ready", bus.cdb_req, 1);
    check_eq("t6_head_value", bus.cdb_value, 143);
    step();
    nb0 = n_bcast;
    bus.recovery_request = 1'b1;
    bus.recovery_b_mask  = 4'b0100;
    bus.cdb_gnt          = 1'b1;
    @(negedge clk);
    check_eq("t6_req_masked", bus.cdb_req, 0);
    step();
    bus.recovery_request = 1'b0;
    bus.recovery_b_mask  = '0;
    lat = 0;
    while (lat < 5) begin
      @(negedge clk);
      lat++;
      if (bus.cdb_req) break;
    end
    check_eq("t6_next_value", bus.cdb_value, 323);
    repeat (3) step();
    check_eq("t6_bcast", n_bcast - nb0, 1);

    // Reset mid-flight: late done pulses are dropped.
    do_reset();
    bus.rs_req = 2'b11;
    for (int c = 0; c < 3; c++) begin
      rand_ops(c);
      step();
    end
    do_reset();
    nb0 = n_bcast;
    repeat (15) step();
    check_eq("t7_dropped", n_bcast - nb0, 0);
    check_eq("t7_credits", dut.credits_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
